// File: rtl/common_if_mem_slaver_if.sv
// ---------------------------------------------------------------------------
// common_if_mem_slaver_if
// Interface for the common command/burst bus between a master and the
// common_if_mem_slaver responder.
//   command : cmd_vld, cmd, addr, burst_len -> ; cmd_ready, finish, status <-
//   write   : wr_vld, wr_data, wr_last      -> ; wr_ready <-
//   read    : rd_ready                      -> ; rd_vld, rd_data, rd_last <-
// Modports: master (drives commands and write beats) and slave.
// ---------------------------------------------------------------------------
interface common_if_mem_slaver_if #(
  parameter int CSIZE = 4,
  parameter int LSIZE = 24,
  parameter int DSIZE = 32,
  parameter int ASIZE = 10
) ();
  logic             cmd_vld;
  logic [CSIZE-1:0] cmd;
  logic [ASIZE-1:0] addr;
  logic [LSIZE-1:0] burst_len;
  logic             cmd_ready;
  logic             finish;
  logic [3:0]       status;
  logic             wr_vld;
  logic [DSIZE-1:0] wr_data;
  logic             wr_last;
  logic             wr_ready;
  logic             rd_ready;
  logic             rd_vld;
  logic [DSIZE-1:0] rd_data;
  logic             rd_last;

  modport master (
    output cmd_vld, cmd, addr, burst_len, wr_vld, wr_data, wr_last, rd_ready,
    input  cmd_ready, finish, status, wr_ready, rd_vld, rd_data, rd_last
  );

  modport slave (
    input  cmd_vld, cmd, addr, burst_len, wr_vld, wr_data, wr_last, rd_ready,
    output cmd_ready, finish, status, wr_ready, rd_vld, rd_data, rd_last
  );
endinterface

// File: rtl/common_if_mem_slaver.sv
// ---------------------------------------------------------------------------
// common_if_mem_slaver
// Slave-side responder on the common command/burst bus. Accepts one command
// at a time and serves write or read bursts against an internal memory of
// 2**ASIZE words of DSIZE bits. Completion is a one-cycle finish pulse with a
// 4-bit status (0 OK, 1 illegal cmd, 2 zero burst_len, 3 wr_last mismatch).
// Ports:
//   clock  : system clock
//   rst    : synchronous active-high reset
//   clk_en : advance enable; when low, every register and handshake freezes
//   bus    : common_if_mem_slaver_if slave modport (command/write/read)
// ---------------------------------------------------------------------------
module common_if_mem_slaver #(
  parameter int CSIZE = 4,
  parameter int LSIZE = 24,
  parameter int DSIZE = 32,
  parameter int ASIZE = 10
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic                   clk_en,
  common_if_mem_slaver_if.slave  bus
);

  localparam logic [CSIZE-1:0] CMD_WRITE = CSIZE'(1);
  localparam logic [CSIZE-1:0] CMD_READ  = CSIZE'(2);

  localparam logic [3:0] ST_OK       = 4'd0;
  localparam logic [3:0] ST_ILLEGAL  = 4'd1;
  localparam logic [3:0] ST_ZERO_LEN = 4'd2;
  localparam logic [3:0] ST_LAST_ERR = 4'd3;

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t           state_reg;
  logic [ASIZE-1:0] cur_addr_reg;
  logic [LSIZE-1:0] len_reg;
  logic [LSIZE-1:0] beat_cnt_reg;

  logic             cmd_ready_reg;
  logic             finish_reg;
  logic [3:0]       status_reg;
  logic             wr_ready_reg;
  logic             rd_vld_reg;
  logic [DSIZE-1:0] rd_data_reg;
  logic             rd_last_reg;

  logic [DSIZE-1:0] mem [0:(1<<ASIZE)-1];

  logic wr_beat;
  logic wr_final;

  // wr_ready_reg is high only in WRITE, so it qualifies the beat by itself.
  assign wr_beat  = wr_ready_reg && bus.wr_vld;
  assign wr_final = (beat_cnt_reg + LSIZE'(1)) == len_reg;

  assign bus.cmd_ready = cmd_ready_reg;
  assign bus.finish    = finish_reg;
  assign bus.status    = status_reg;
  assign bus.wr_ready  = wr_ready_reg;
  assign bus.rd_vld    = rd_vld_reg;
  assign bus.rd_data   = rd_data_reg;
  assign bus.rd_last   = rd_last_reg;

  // Memory write port kept free of reset so it maps onto block RAM; contents
  // survive reset, and a beat coinciding with reset is dropped.
  always_ff @(posedge clock) begin
    if (!rst && clk_en && wr_beat) begin
      mem[cur_addr_reg] <= bus.wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_reg     <= IDLE;
      cur_addr_reg  <= '0;
      len_reg       <= '0;
      beat_cnt_reg  <= '0;
      cmd_ready_reg <= 1'b1;
      finish_reg    <= 1'b0;
      status_reg    <= ST_OK;
      wr_ready_reg  <= 1'b0;
      rd_vld_reg    <= 1'b0;
      rd_data_reg   <= '0;
      rd_last_reg   <= 1'b0;
    end else if (clk_en) begin
      // finish is a single qualified-cycle pulse; while clk_en is low it
      // simply holds, so it never repeats.
      finish_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.cmd_vld) begin
            cmd_ready_reg <= 1'b0;
            cur_addr_reg  <= bus.addr;
            len_reg       <= bus.burst_len;
            beat_cnt_reg  <= '0;
            status_reg    <= ST_OK;
            if (bus.cmd != CMD_WRITE && bus.cmd != CMD_READ) begin
              status_reg <= ST_ILLEGAL;
              finish_reg <= 1'b1;
              state_reg  <= DONE;
            end else if (bus.burst_len == '0) begin
              status_reg <= ST_ZERO_LEN;
              finish_reg <= 1'b1;
              state_reg  <= DONE;
            end else if (bus.cmd == CMD_WRITE) begin
              wr_ready_reg <= 1'b1;
              state_reg    <= WRITE;
            end else begin
              // First read word is fetched at accept so it is presented on
              // the very next cycle; cur_addr then points one word ahead.
              rd_vld_reg   <= 1'b1;
              rd_data_reg  <= mem[bus.addr];
              rd_last_reg  <= bus.burst_len == LSIZE'(1);
              cur_addr_reg <= bus.addr + ASIZE'(1);
              state_reg    <= READ;
            end
          end
        end

        WRITE: begin
          if (wr_beat) begin
            cur_addr_reg <= cur_addr_reg + ASIZE'(1);
            beat_cnt_reg <= beat_cnt_reg + LSIZE'(1);
            if (wr_final || bus.wr_last) begin
              wr_ready_reg <= 1'b0;
              finish_reg   <= 1'b1;
              status_reg   <= (wr_final && bus.wr_last) ? ST_OK : ST_LAST_ERR;
              state_reg    <= DONE;
            end
          end
        end

        READ: begin
          // rd_vld_reg is high throughout READ; outputs hold while stalled.
          if (rd_vld_reg && bus.rd_ready) begin
            if (rd_last_reg) begin
              rd_vld_reg  <= 1'b0;
              rd_last_reg <= 1'b0;
              finish_reg  <= 1'b1;
              status_reg  <= ST_OK;
              state_reg   <= DONE;
            end else begin
              rd_data_reg  <= mem[cur_addr_reg];
              cur_addr_reg <= cur_addr_reg + ASIZE'(1);
              beat_cnt_reg <= beat_cnt_reg + LSIZE'(1);
              // Next presented word has index beat_cnt+1; it is last when
              // that equals len-1.
              rd_last_reg  <= (beat_cnt_reg + LSIZE'(2)) == len_reg;
            end
          end
        end

        DONE: begin
          cmd_ready_reg <= 1'b1;
          state_reg     <= IDLE;
        end

        default: begin
          cmd_ready_reg <= 1'b1;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_common_if_mem_slaver.sv
// ---------------------------------------------------------------------------
// tb_common_if_mem_slaver
// Directed self-checking bench for common_if_mem_slaver. Inputs are driven
// and outputs sampled on the falling clock edge; DUT updates on the rising
// edge. A monitor counts qualified finish pulses and their status.
// ---------------------------------------------------------------------------
module tb_common_if_mem_slaver;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  logic clk_en = 1'b1;

  always #5 clock = ~clock;

  common_if_mem_slaver_if #(.CSIZE(4), .LSIZE(24), .DSIZE(32), .ASIZE(10)) bus ();

  common_if_mem_slaver #(.CSIZE(4), .LSIZE(24), .DSIZE(32), .ASIZE(10)) dut (
    .clock  (clock),
    .rst    (rst),
    .clk_en (clk_en),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;

  int         fin_cnt = 0;
  logic [3:0] fin_status = 4'd0;

  always @(posedge clock) begin
    if (bus.finish && clk_en && !rst) begin
      fin_cnt = fin_cnt + 1;
      fin_status = bus.status;
    end
  end

  logic [31:0] rd_buf  [0:15];
  logic        rd_lbuf [0:15];
  int          rd_n;
  int          acc;
  int          fin0;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [3:0] c, input logic [9:0] a, input logic [23:0] l);
    bus.cmd_vld   = 1'b1;
    bus.cmd       = c;
    bus.addr      = a;
    bus.burst_len = l;
    tick();
    bus.cmd_vld   = 1'b0;
    $display("cmd=%0d addr=%03h len=%0d issued", c, a, l);
  endtask

  // Offers n beats base, base+1, ...; wr_last on beat number last_at (1-based,
  // 0 = never). Counts beats offered while wr_ready was high.
  task automatic write_beats(input int n, input logic [31:0] base, input int last_at,
                             output int accepted);
    accepted = 0;
    for (int i = 0; i < n; i++) begin
      bus.wr_vld  = 1'b1;
      bus.wr_data = base + 32'(i);
      bus.wr_last = (i + 1 == last_at);
      if (bus.wr_ready) accepted++;
      tick();
    end
    bus.wr_vld  = 1'b0;
    bus.wr_last = 1'b0;
    $display("write burst base=%0h offered=%0d accepted=%0d", base, n, accepted);
  endtask

  // Holds rd_ready high for ncyc cycles and records every transfer.
  task automatic read_beats(input int ncyc);
    rd_n = 0;
    for (int i = 0; i < ncyc; i++) begin
      bus.rd_ready = 1'b1;
      if (bus.rd_vld && rd_n < 16) begin
        rd_buf[rd_n]  = bus.rd_data;
        rd_lbuf[rd_n] = bus.rd_last;
        rd_n++;
      end
      tick();
    end
    bus.rd_ready = 1'b0;
    $display("read burst cycles=%0d transfers=%0d", ncyc, rd_n);
  endtask

  initial begin
    bus.cmd_vld   = 1'b0;
    bus.cmd       = '0;
    bus.addr      = '0;
    bus.burst_len = '0;
    bus.wr_vld    = 1'b0;
    bus.wr_data   = '0;
    bus.wr_last   = 1'b0;
    bus.rd_ready  = 1'b0;

    // Reset state
    tick(); tick(); tick();
    chk1("rst_cmd_ready", bus.cmd_ready, 1'b1);
    chk1("rst_finish", bus.finish, 1'b0);
    chk4("rst_status", bus.status, 4'd0);
    chk1("rst_wr_ready", bus.wr_ready, 1'b0);
    chk1("rst_rd_vld", bus.rd_vld, 1'b0);
    chk32("rst_rd_data", bus.rd_data, 32'h0);
    chk1("rst_rd_last", bus.rd_last, 1'b0);
    rst = 1'b0;
    tick();

    // Write 4 words at 0x010
    send_cmd(4'd1, 10'h010, 24'd4);
    chk1("wr_cmd_ready_low", bus.cmd_ready, 1'b0);
    chk1("wr_ready_up", bus.wr_ready, 1'b1);
    write_beats(4, 32'hA0, 4, acc);
    chk32("wr_accepted", 32'(acc), 32'd4);
    chk1("wr_finish", bus.finish, 1'b1);
    chk4("wr_status", bus.status, 4'd0);
    chk1("wr_ready_down", bus.wr_ready, 1'b0);
    tick();
    chk1("wr_finish_once", bus.finish, 1'b0);
    chk1("wr_back_idle", bus.cmd_ready, 1'b1);
    chk32("wr_fin_cnt", 32'(fin_cnt), 32'd1);

    // Read them back at full rate
    send_cmd(4'd2, 10'h010, 24'd4);
    chk1("rd_first_vld", bus.rd_vld, 1'b1);
    chk32("rd_first_data", bus.rd_data, 32'hA0);
    read_beats(4);
    chk32("rd_count", 32'(rd_n), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk32("rd_data", rd_buf[i], 32'hA0 + 32'(i));
      chk1("rd_last", rd_lbuf[i], i == 3);
    end
    chk1("rd_vld_end", bus.rd_vld, 1'b0);
    chk1("rd_finish", bus.finish, 1'b1);
    chk4("rd_status", bus.status, 4'd0);
    tick();

    // Address wrap
    send_cmd(4'd1, 10'h3FE, 24'd3);
    write_beats(3, 32'd1, 3, acc);
    chk32("wrap_wr_accepted", 32'(acc), 32'd3);
    chk4("wrap_wr_status", bus.status, 4'd0);
    tick();
    send_cmd(4'd2, 10'h3FE, 24'd3);
    read_beats(3);
    chk32("wrap_rd_count", 32'(rd_n), 32'd3);
    chk32("wrap_rd0", rd_buf[0], 32'd1);
    chk32("wrap_rd1", rd_buf[1], 32'd2);
    chk32("wrap_rd2", rd_buf[2], 32'd3);
    tick();
    send_cmd(4'd2, 10'h000, 24'd1);
    chk1("wrap_mem0_last", bus.rd_last, 1'b1);
    read_beats(1);
    chk32("wrap_mem0", rd_buf[0], 32'd3);
    tick();

    // Read backpressure: rd_ready 0,0,1,0,1
    send_cmd(4'd2, 10'h010, 24'd2);
    bus.rd_ready = 1'b0;
    chk32("bp_c0_data", bus.rd_data, 32'hA0);
    chk1("bp_c0_last", bus.rd_last, 1'b0);
    tick();
    chk32("bp_c1_data", bus.rd_data, 32'hA0);
    chk1("bp_c1_vld", bus.rd_vld, 1'b1);
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
    chk32("bp_c3_data", bus.rd_data, 32'hA1);
    chk1("bp_c3_last", bus.rd_last, 1'b1);
    tick();
    chk32("bp_c4_data", bus.rd_data, 32'hA1);
    chk1("bp_c4_vld", bus.rd_vld, 1'b1);
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
    chk1("bp_done_vld", bus.rd_vld, 1'b0);
    chk1("bp_finish", bus.finish, 1'b1);
    $display("backpressure read len=2 done");
    tick();

    // Illegal command
    send_cmd(4'h7, 10'h000, 24'd4);
    chk1("ill_finish", bus.finish, 1'b1);
    chk4("ill_status", bus.status, 4'd1);
    chk1("ill_wr_ready", bus.wr_ready, 1'b0);
    chk1("ill_rd_vld", bus.rd_vld, 1'b0);
    tick();
    chk1("ill_finish_gone", bus.finish, 1'b0);
    chk4("ill_status_held", bus.status, 4'd1);

    // Zero length
    send_cmd(4'd1, 10'h000, 24'd0);
    chk1("zero_finish", bus.finish, 1'b1);
    chk4("zero_status", bus.status, 4'd2);
    chk1("zero_wr_ready", bus.wr_ready, 1'b0);
    tick();

    // Early wr_last on beat 2 of 4
    fin0 = fin_cnt;
    send_cmd(4'd1, 10'h100, 24'd4);
    write_beats(4, 32'hB0, 2, acc);
    chk32("early_accepted", 32'(acc), 32'd2);
    chk32("early_fin_cnt", 32'(fin_cnt - fin0), 32'd1);
    chk4("early_status", fin_status, 4'd3);
    send_cmd(4'd2, 10'h100, 24'd2);
    read_beats(2);
    chk32("early_rd0", rd_buf[0], 32'hB0);
    chk32("early_rd1", rd_buf[1], 32'hB1);
    tick();

    // No wr_last on final beat
    send_cmd(4'd1, 10'h200, 24'd2);
    write_beats(2, 32'hC0, 0, acc);
    chk32("nolast_accepted", 32'(acc), 32'd2);
    chk1("nolast_finish", bus.finish, 1'b1);
    chk4("nolast_status", bus.status, 4'd3);
    tick();
    send_cmd(4'd2, 10'h200, 24'd2);
    read_beats(2);
    chk32("nolast_rd0", rd_buf[0], 32'hC0);
    chk32("nolast_rd1", rd_buf[1], 32'hC1);
    tick();

    // clk_en low for 5 cycles mid-read, then across finish
    send_cmd(4'd1, 10'h300, 24'd4);
    write_beats(4, 32'hD0, 4, acc);
    tick();
    send_cmd(4'd2, 10'h300, 24'd4);
    chk32("ce_first", bus.rd_data, 32'hD0);
    bus.rd_ready = 1'b1;
    tick();
    clk_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk32("ce_hold_data", bus.rd_data, 32'hD1);
      chk1("ce_hold_vld", bus.rd_vld, 1'b1);
    end
    clk_en = 1'b1;
    read_beats(3);
    chk32("ce_count", 32'(rd_n), 32'd3);
    chk32("ce_rd0", rd_buf[0], 32'hD1);
    chk32("ce_rd1", rd_buf[1], 32'hD2);
    chk32("ce_rd2", rd_buf[2], 32'hD3);
    chk1("ce_rd2_last", rd_lbuf[2], 1'b1);
    chk1("ce_finish", bus.finish, 1'b1);
    fin0 = fin_cnt;
    clk_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("ce_finish_held", bus.finish, 1'b1);
    end
    clk_en = 1'b1;
    tick();
    chk1("ce_finish_gone", bus.finish, 1'b0);
    chk1("ce_idle", bus.cmd_ready, 1'b1);
    chk32("ce_fin_once", 32'(fin_cnt - fin0), 32'd1);

    // Reset mid-write after beat 2 of 8
    send_cmd(4'd1, 10'h080, 24'd8);
    write_beats(2, 32'hE0, 0, acc);
    chk32("rstmid_accepted", 32'(acc), 32'd2);
    fin0 = fin_cnt;
    rst = 1'b1;
    tick();
    chk1("rstmid_cmd_ready", bus.cmd_ready, 1'b1);
    chk1("rstmid_wr_ready", bus.wr_ready, 1'b0);
    chk1("rstmid_finish", bus.finish, 1'b0);
    rst = 1'b0;
    tick(); tick();
    chk32("rstmid_no_finish", 32'(fin_cnt - fin0), 32'd0);
    send_cmd(4'd2, 10'h080, 24'd2);
    read_beats(2);
    chk32("rstmid_rd0", rd_buf[0], 32'hE0);
    chk32("rstmid_rd1", rd_buf[1], 32'hE1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
